count_event_monitor: RTL and testbench
======================================

COUNT_EVENT_MONITOR -- requirements
Module: count_event_monitor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, which sets the width of the monitored count value.
REQ-002 The block SHALL have parameter WCW, default 8, which sets the width of the wrap event counter.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-005 The block SHALL have port cnt_in, input, WIDTH bits, the count value from the upstream up/down counter (its data_out).
REQ-006 The block SHALL have port cnt_valid, input, 1 bit; when high, cnt_in is a new sample.
REQ-007 The block SHALL have port thresh, input, WIDTH bits, the match threshold, sampled each valid cycle.
REQ-008 The block SHALL have port clr, input, 1 bit, a synchronous clear of the sticky error and the wrap count.
REQ-009 The block SHALL have port state, output, 2 bits, the FSM state: 00 IDLE, 01 HOLD, 10 UP, 11 DOWN.
REQ-010 The block SHALL have port wrap_pulse, output, 1 bit, a one-cycle pulse on a wrap-around.
REQ-011 The block SHALL have port match_pulse, output, 1 bit, a one-cycle pulse when the count enters thresh.
REQ-012 The block SHALL have port wrap_count, output, WCW bits, the saturating count of wraps.
REQ-013 The block SHALL have port err, output, 1 bit, a sticky flag set on an illegal step.

Function
REQ-014 The block SHALL register all outputs; a sample accepted at edge N SHALL be reflected in the outputs after edge N, i.e. with 1-cycle latency.
REQ-015 The block SHALL hold an internal register prev (WIDTH bits) holding the last accepted sample; prev SHALL be loaded on every cycle where cnt_valid=1.
REQ-016 The block SHALL compute step classification, in a valid cycle with state != IDLE, as delta = (cnt_in - prev) mod 2^WIDTH, where: delta=0 -> hold; delta=1 -> up; delta=2^WIDTH-1 -> down; any other value -> jump.
REQ-017 The FSM SHALL behave as follows in IDLE: valid -> HOLD; prev is captured; no pulses, no classification.
REQ-018 The FSM SHALL behave as follows in HOLD, UP or DOWN: hold -> HOLD; up -> UP; down -> DOWN; jump -> HOLD and err set to 1.
REQ-019 The block SHALL leave the state unchanged and deassert both pulses when cnt_valid=0.
REQ-020 The block SHALL detect a wrap, by asserting wrap_pulse=1 for one cycle, on an up step with prev=2^WIDTH-1 (F->0 for WIDTH 4) or a down step with prev=0 (0->F).
REQ-021 The block SHALL increment wrap_count on each wrap_pulse and saturate it at 2^WCW-1 with no rollover.
REQ-022 The block SHALL assert match_pulse=1 for one cycle when, in a valid non-IDLE cycle, cnt_in==thresh and prev!=thresh; a repeated hold at thresh SHALL NOT re-pulse.
REQ-023 The block SHALL never assert match_pulse on the first sample after IDLE.
REQ-024 The block SHALL NOT produce a wrap_pulse on a jump, even if the jump crosses 0/max.
REQ-025 When clr=1, the block SHALL clear err and wrap_count to 0 on the next edge, with clr taking priority over a same-cycle err set or wrap increment.
REQ-026 The block SHALL still assert wrap_pulse and match_pulse normally when clr=1, and SHALL keep state and prev unaffected by clr.
REQ-027 The block SHALL be a pure observer, with no back-pressure on the upstream counter.

Reset
REQ-028 When rst=1 at a rising edge, the block SHALL set state=IDLE, prev=0, wrap_pulse=0, match_pulse=0, wrap_count=0 and err=0.
REQ-029 The block SHALL give rst priority over clr and cnt_valid.
REQ-030 The block SHALL treat a rst asserted mid-sequence as discarding prev, and SHALL NOT classify the first valid sample after reset.
REQ-031 The block SHALL NOT require a reset of the upstream counter at the same time.

Verification
REQ-032 The bench SHALL drive rst for 1 cycle and then valid samples 0,1,2,3 -> state HOLD,UP,UP,UP; no pulses; err=0.
REQ-033 The bench SHALL drive valid samples E,F,0,1 with thresh=0 -> wrap_pulse and match_pulse both high in the cycle after sample 0; wrap_count=1; state UP.
REQ-034 The bench SHALL drive valid samples 1,0,F,E -> wrap_pulse after F; state DOWN; wrap_count increments by 1.
REQ-035 The bench SHALL drive valid samples 2,6 -> err=1 and state HOLD; next sample 7 -> state UP with err still 1; then clr=1 -> err=0.
REQ-036 The bench SHALL force 300 F->0 wraps with WCW=8 -> wrap_count stops at 255; then clr asserted in the same cycle as a wrap -> wrap_count=0 and wrap_pulse=1.
REQ-037 The bench SHALL assert rst after samples 4,5, then drive sample 9 -> state HOLD with no err and no pulses; then sample A -> state UP.

Source files
------------

// File: rtl/count_event_monitor.sv
// Observes an up/down counter's samples: classifies steps, flags wraps, threshold entry and illegal jumps.
// Outputs are registered (1-cycle latency); pure observer, never back-pressures the upstream counter.
module count_event_monitor #(
  parameter int WIDTH = 4,
  parameter int WCW   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             cnt_valid,
  input  logic [WIDTH-1:0] thresh,
  input  logic             clr,
  output logic [1:0]       state,
  output logic             wrap_pulse,
  output logic             match_pulse,
  output logic [WCW-1:0]   wrap_count,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_HOLD = 2'b01,
    S_UP   = 2'b10,
    S_DOWN = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             wrap_q, wrap_d;
  logic             match_q, match_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] delta;

  assign delta = cnt_in - prev_q;

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    wrap_d  = 1'b0;
    match_d = 1'b0;
    wcnt_d  = wcnt_q;
    err_d   = err_q;

    if (cnt_valid) begin
      prev_d = cnt_in;
      if (state_q == S_IDLE) begin
        // First sample only seeds prev; there is no step to classify yet.
        state_d = S_HOLD;
      end else begin
        if (delta == '0) begin
          state_d = S_HOLD;
        end else if (delta == WIDTH'(1)) begin
          state_d = S_UP;
          wrap_d  = (prev_q == '1);
        end else if (delta == '1) begin
          state_d = S_DOWN;
          wrap_d  = (prev_q == '0);
        end else begin
          state_d = S_HOLD;
          err_d   = 1'b1;
        end
        match_d = (cnt_in == thresh) && (prev_q != thresh);
      end
    end

    if (wrap_d && (wcnt_q != '1)) begin
      wcnt_d = wcnt_q + WCW'(1);
    end

    // Clear wins over a same-cycle error or wrap increment; pulses are untouched.
    if (clr) begin
      err_d  = 1'b0;
      wcnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      prev_q  <= '0;
      wrap_q  <= 1'b0;
      match_q <= 1'b0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      wrap_q  <= wrap_d;
      match_q <= match_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end

  assign state       = state_q;
  assign wrap_pulse  = wrap_q;
  assign match_pulse = match_q;
  assign wrap_count  = wcnt_q;
  assign err         = err_q;

endmodule

// File: tb/tb_count_event_monitor.sv
// Bench for count_event_monitor: directed scenarios plus random samples against a behavioural model.
module tb_count_event_monitor;
  localparam int W  = 4;
  localparam int WC = 8;
  localparam int MAXV  = (1 << W) - 1;
  localparam int MAXWC = (1 << WC) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cnt_valid = 1'b0;
  logic          clr = 1'b0;
  logic [W-1:0]  cnt_in = '0;
  logic [W-1:0]  thresh = '0;
  logic [1:0]    state;
  logic          wrap_pulse;
  logic          match_pulse;
  logic [WC-1:0] wrap_count;
  logic          err;

  int n_cmp = 0;
  int n_mis = 0;

  // Model: state codes 0 idle, 1 hold, 2 up, 3 down.
  int m_state = 0, m_prev = 0, m_wrap = 0, m_match = 0, m_wc = 0, m_err = 0;

  count_event_monitor #(.WIDTH(W), .WCW(WC)) dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .cnt_valid(cnt_valid),
    .thresh(thresh), .clr(clr), .state(state), .wrap_pulse(wrap_pulse),
    .match_pulse(match_pulse), .wrap_count(wrap_count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update(input int v, input int val, input int thr, input int c, input int r);
    int d;
    if (r != 0) begin
      m_state = 0; m_prev = 0; m_wrap = 0; m_match = 0; m_wc = 0; m_err = 0;
      return;
    end
    m_wrap  = 0;
    m_match = 0;
    if (v != 0) begin
      if (m_state == 0) begin
        m_state = 1;
      end else begin
        d = (val - m_prev + MAXV + 1) % (MAXV + 1);
        if (d == 0) m_state = 1;
        else if (d == 1) begin
          m_state = 2;
          m_wrap  = (m_prev == MAXV) ? 1 : 0;
        end else if (d == MAXV) begin
          m_state = 3;
          m_wrap  = (m_prev == 0) ? 1 : 0;
        end else begin
          m_state = 1;
          m_err   = 1;
        end
        m_match = (val == thr && m_prev != thr) ? 1 : 0;
      end
      m_prev = val;
    end
    if (m_wrap != 0 && m_wc < MAXWC) m_wc = m_wc + 1;
    if (c != 0) begin
      m_err = 0;
      m_wc  = 0;
    end
  endtask

  task automatic step(input int v, input int val, input int thr, input int c, input int r);
    @(negedge clk);
    cnt_valid = (v != 0);
    cnt_in    = W'(val);
    thresh    = W'(thr);
    clr       = (c != 0);
    rst       = (r != 0);
    @(posedge clk);
    model_update(v, val, thr, c, r);
    #1;
    check("state", 32'(state), 32'(m_state));
    check("wrap_pulse", 32'(wrap_pulse), 32'(m_wrap));
    check("match_pulse", 32'(match_pulse), 32'(m_match));
    check("wrap_count", 32'(wrap_count), 32'(m_wc));
    check("err", 32'(err), 32'(m_err));
  endtask

  initial begin
    int pick;
    int val;

    // Reset and basic counting up
    step(0, 0, 0, 0, 1);
    check("rst_state", 32'(state), 0);
    check("rst_wc", 32'(wrap_count), 0);
    step(1, 0, 15, 0, 0);
    check("first_hold", 32'(state), 1);
    for (int i = 1; i <= 3; i++) step(1, i, 15, 0, 0);
    check("up_state", 32'(state), 2);
    check("up_err", 32'(err), 0);

    // Up wrap into threshold 0
    step(0, 0, 0, 1, 0);
    step(1, 14, 0, 0, 0);
    step(1, 15, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("upwrap_pulse", 32'(wrap_pulse), 1);
    check("upwrap_match", 32'(match_pulse), 1);
    check("upwrap_wc", 32'(wrap_count), 1);
    step(1, 1, 0, 0, 0);
    check("upwrap_state", 32'(state), 2);

    // Down wrap
    step(1, 1, 15, 0, 0);
    step(1, 0, 15, 0, 0);
    step(1, 15, 15, 0, 0);
    check("dnwrap_pulse", 32'(wrap_pulse), 1);
    check("dnwrap_wc", 32'(wrap_count), 2);
    check("dnwrap_match", 32'(match_pulse), 1);
    step(1, 14, 15, 0, 0);
    check("dn_state", 32'(state), 3);

    // Illegal jump, sticky error, clear
    step(1, 2, 0, 0, 0);
    step(1, 6, 0, 0, 0);
    check("jump_err", 32'(err), 1);
    check("jump_state", 32'(state), 1);
    step(1, 7, 0, 0, 0);
    check("post_jump_state", 32'(state), 2);
    check("post_jump_err", 32'(err), 1);
    step(0, 7, 0, 1, 0);
    check("clr_err", 32'(err), 0);

    // Saturation of the wrap counter
    for (int i = 0; i < 300; i++) begin
      step(1, 15, 3, 0, 0);
      step(1, 0, 3, 0, 0);
    end
    check("sat_wc", 32'(wrap_count), MAXWC);
    step(1, 15, 3, 0, 0);
    step(1, 0, 3, 1, 0);
    check("clr_wrap_wc", 32'(wrap_count), 0);
    check("clr_wrap_pulse", 32'(wrap_pulse), 1);

    // Reset mid-sequence discards prev
    step(1, 4, 0, 0, 0);
    step(1, 5, 0, 0, 0);
    step(0, 5, 0, 0, 1);
    step(1, 9, 9, 0, 0);
    check("rst_mid_state", 32'(state), 1);
    check("rst_mid_err", 32'(err), 0);
    check("rst_mid_match", 32'(match_pulse), 0);
    step(1, 10, 9, 0, 0);
    check("rst_mid_up", 32'(state), 2);

    // Random samples, biased toward legal steps
    for (int i = 0; i < 600; i++) begin
      pick = int'($urandom_range(0, 9));
      case (pick)
        0, 1, 2: val = (m_prev + 1) % (MAXV + 1);
        3, 4:    val = (m_prev + MAXV) % (MAXV + 1);
        5, 6:    val = m_prev;
        default: val = int'($urandom_range(0, MAXV));
      endcase
      step(($urandom_range(0, 4) != 0) ? 1 : 0, val, int'($urandom_range(0, MAXV)),
           ($urandom_range(0, 24) == 0) ? 1 : 0, ($urandom_range(0, 99) == 0) ? 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
